// File: rtl/data_mem_ctrl_if.sv
// MEM <-> data memory bus: request strobes, address, store data and size
// from MEM; registered read data, stall and error pulse back to MEM.
// master = MEM stage side, slave = data memory controller side.
interface data_mem_ctrl_if;
    logic [31:0] data_address_2DM;     // byte address
    logic [31:0] data_write_2DM;       // store data, low-order N bytes used
    logic [1:0]  data_write_size_2DM;  // 0=4 bytes, 1..3 = that many bytes
    logic        MemRead_2DM;          // load request
    logic        MemWrite_2DM;         // store request
    logic [31:0] data_read_fDM;        // aligned word, registered
    logic        MEM_stall;            // hold upstream while access pending
    logic        bad_addr_err;         // one-cycle error pulse in DONE

    modport master (
        output data_address_2DM, data_write_2DM, data_write_size_2DM,
               MemRead_2DM, MemWrite_2DM,
        input  data_read_fDM, MEM_stall, bad_addr_err
    );

    modport slave (
        input  data_address_2DM, data_write_2DM, data_write_size_2DM,
               MemRead_2DM, MemWrite_2DM,
        output data_read_fDM, MEM_stall, bad_addr_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Purpose: multi-cycle big-endian byte-addressed data memory behind MEM.
// Latency: READ_LATENCY cycles from request acceptance to the DONE cycle.
// Backpressure: MEM_stall high from the accept cycle until DONE; inputs ignored while busy.
//
// Ports: CLK, RESET (async active-high), dm (data_mem_ctrl_if.slave).
// Optional feature: define DM_MISALIGN_TRAP_EN to trap word-crossing accesses;
// otherwise crossing bytes wrap inside the addressed word.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic           CLK,
    input  logic           RESET,
    data_mem_ctrl_if.slave dm
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [1:0]     r_size;
    logic           r_wr;
    logic [31:0]    r_data;
    logic           r_err;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_req;
    logic           w_accept;
    logic           w_finish;
    logic [31:0]    w_a_addr;
    logic [31:0]    w_a_wdata;
    logic [1:0]     w_a_size;
    logic           w_a_wr;
    logic           w_in_range;
    logic [AW-1:0]  w_idx;
    logic [31:0]    w_old;
    logic [2:0]     w_nbytes;
    logic           w_illegal;
    logic [31:0]    w_merged;
    logic           w_commit;

    assign w_req    = dm.MemRead_2DM | dm.MemWrite_2DM;
    assign w_accept = (r_state == S_IDLE) && w_req;

    // With READ_LATENCY=1 the access completes on the accept edge, before
    // the latches are loaded, so the access fields come straight from the bus
    // while IDLE and from the latches afterwards.
    assign w_a_addr  = (r_state == S_IDLE) ? dm.data_address_2DM    : r_addr;
    assign w_a_wdata = (r_state == S_IDLE) ? dm.data_write_2DM      : r_wdata;
    assign w_a_size  = (r_state == S_IDLE) ? dm.data_write_size_2DM : r_size;
    assign w_a_wr    = (r_state == S_IDLE) ? dm.MemWrite_2DM        : r_wr;

    assign w_finish = (w_accept && (READ_LATENCY == 1)) ||
                      ((r_state == S_BUSY) && (r_cnt == CW'(1)));

    // Only the word address is range-checked; high bits never alias.
    assign w_in_range = ({2'b00, w_a_addr[31:2]} < 32'(DEPTH_WORDS));
    assign w_idx      = w_a_addr[AW+1:2];
    assign w_old      = w_in_range ? r_mem[w_idx] : 32'h0;
    assign w_nbytes   = (w_a_size == 2'd0) ? 3'd4 : {1'b0, w_a_size};

`ifdef DM_MISALIGN_TRAP_EN
    logic w_cross;
    assign w_cross   = (({1'b0, w_a_addr[1:0]} + w_nbytes) > 3'd4);
    // Full-word loads are aligned by MEM, so they never trap.
    assign w_illegal = ~w_in_range |
                       (w_cross & ~(~w_a_wr & (w_a_size == 2'd0)));
`else
    assign w_illegal = ~w_in_range;
`endif

    // Byte k of the store lands at offset (A[1:0]+k) mod 4, taking the
    // k-th most significant used byte of the data. Offset 0 is bits [31:24].
    always_comb begin
        w_merged = w_old;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_nbytes) begin
                w_merged[{~(w_a_addr[1:0] + 2'(k)), 3'b000} +: 8] =
                    8'(w_a_wdata >> {w_nbytes - 3'(k) - 3'd1, 3'b000});
            end
        end
    end

    assign w_commit = w_finish & w_a_wr & ~w_illegal & ~RESET;

    // Array is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_wr    <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr  <= dm.data_address_2DM;
                        r_wdata <= dm.data_write_2DM;
                        r_size  <= dm.data_write_size_2DM;
                        r_wr    <= dm.MemWrite_2DM;
                        r_cnt   <= CW'(READ_LATENCY - 1);
                        r_state <= (READ_LATENCY == 1) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Read data is the pre-store word (zero when out of range).
            if (w_finish) begin
                r_data <= w_old;
                r_err  <= w_illegal;
            end
        end
    end

    assign dm.MEM_stall     = ((r_state == S_BUSY) | w_accept) & ~RESET;
    assign dm.data_read_fDM = r_data;
    assign dm.bad_addr_err  = r_err;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte-level memory model plus per-cycle compare
// of stall, error pulse and read data, and literal checks of known words.
module tb_data_mem_ctrl;
    localparam int DEPTH = 1024;
    localparam int RL    = 2;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    data_mem_ctrl_if bus();

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(RL)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .dm    (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model state: one byte per address, plus whether each byte is defined.
    logic [7:0]  m_byte  [DEPTH*4];
    bit          m_known [DEPTH*4];

    // Expected outputs for the current cycle.
    bit          chk_en = 1'b0;
    logic        e_stall = 1'b0;
    logic        e_err   = 1'b0;
    logic [31:0] e_data  = 32'h0;
    bit          e_dk    = 1'b1;   // expected data is defined

    always @(negedge CLK) begin
        if (chk_en) begin
            n_vec++;
            if (bus.MEM_stall !== e_stall) begin
                n_bad++;
                $display("FAIL stall @%0t: got %b want %b", $time, bus.MEM_stall, e_stall);
            end
            n_vec++;
            if (bus.bad_addr_err !== e_err) begin
                n_bad++;
                $display("FAIL bad_addr_err @%0t: got %b want %b", $time, bus.bad_addr_err, e_err);
            end
            if (e_dk) begin
                n_vec++;
                if (bus.data_read_fDM !== e_data) begin
                    n_bad++;
                    $display("FAIL read_data @%0t: got %h want %h", $time, bus.data_read_fDM, e_data);
                end
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz);
        int          n;
        bit          inr;
        bit          ill;
        bit          oknown;
        logic [31:0] old;
        logic [31:0] ba;
        n   = (sz == 2'd0) ? 4 : int'(sz);
        inr = (a / 4) < DEPTH;
        ill = !inr;
`ifdef DM_MISALIGN_TRAP_EN
        if ((int'(a[1:0]) + n > 4) && !(!wr && sz == 2'd0)) ill = 1'b1;
`endif
        old    = 32'h0;
        oknown = 1'b1;
        if (inr) begin
            for (int k = 0; k < 4; k++) begin
                ba  = (a & ~32'h3) + 32'(k);
                old = (old << 8) | 32'(m_byte[ba[11:0]]);
                if (!m_known[ba[11:0]]) oknown = 1'b0;
            end
        end
        if (wr && !ill) begin
            for (int k = 0; k < n; k++) begin
                ba = (a & ~32'h3) + 32'((int'(a[1:0]) + k) % 4);
                m_byte[ba[11:0]]  = 8'(d >> (8 * (n - 1 - k)));
                m_known[ba[11:0]] = 1'b1;
            end
        end
        // Accept cycle
        @(posedge CLK); #1;
        bus.data_address_2DM    = a;
        bus.data_write_2DM      = d;
        bus.data_write_size_2DM = sz;
        bus.MemRead_2DM         = rd;
        bus.MemWrite_2DM        = wr;
        e_stall = 1'b1;
        e_err   = 1'b0;
        repeat (RL - 1) begin
            @(posedge CLK); #1;
            e_stall = 1'b1;
        end
        // DONE cycle: drop the request so it is not taken again.
        @(posedge CLK); #1;
        bus.MemRead_2DM  = 1'b0;
        bus.MemWrite_2DM = 1'b0;
        e_stall = 1'b0;
        e_err   = ill;
        e_data  = old;
        e_dk    = oknown;
        // Idle cycle after DONE: error pulse gone, data held.
        @(posedge CLK); #1;
        e_err = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH * 4; i++) begin
            m_byte[i]  = 8'h00;
            m_known[i] = 1'b0;
        end
        RESET = 1'b1;
        bus.data_address_2DM    = 32'h0;
        bus.data_write_2DM      = 32'h0;
        bus.data_write_size_2DM = 2'd0;
        bus.MemRead_2DM         = 1'b0;
        bus.MemWrite_2DM        = 1'b0;
        chk_en = 1'b1;
        #2;
        lit("reset_stall", {31'h0, bus.MEM_stall}, 32'h0);
        lit("reset_err",   {31'h0, bus.bad_addr_err}, 32'h0);
        lit("reset_data",  bus.data_read_fDM, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Word store then load at 0x10
        access(0, 1, 32'h10, 32'hDEADBEEF, 2'd0);
        access(1, 0, 32'h10, 32'h0, 2'd0);
        lit("lw_deadbeef", bus.data_read_fDM, 32'hDEADBEEF);

        // Byte and half stores into 0x11223344
        access(0, 1, 32'h10, 32'h11223344, 2'd0);
        lit("sw_returns_old", bus.data_read_fDM, 32'hDEADBEEF);
        access(0, 1, 32'h12, 32'h000000AA, 2'd1);
        access(1, 0, 32'h10, 32'h0, 2'd0);
        lit("sb_0x12", bus.data_read_fDM, 32'h1122AA44);
        access(0, 1, 32'h10, 32'h0000BBCC, 2'd2);
        access(1, 0, 32'h10, 32'h0, 2'd0);
        lit("sh_0x10", bus.data_read_fDM, 32'hBBCCAA44);

        // Misaligned full-word load returns the aligned word
        access(1, 0, 32'h11, 32'h0, 2'd0);
        lit("lw_misaligned", bus.data_read_fDM, 32'hBBCCAA44);

        // Word-crossing half store at 0x13
        access(0, 1, 32'h13, 32'h00001234, 2'd2);
        access(1, 0, 32'h10, 32'h0, 2'd0);
`ifdef DM_MISALIGN_TRAP_EN
        lit("sh_0x13_trap", bus.data_read_fDM, 32'hBBCCAA44);
`else
        lit("sh_0x13_wrap", bus.data_read_fDM, 32'h34CCAA12);
`endif

        // Three-byte store into word 0
        access(0, 1, 32'h00, 32'h55667788, 2'd0);
        access(0, 1, 32'h01, 32'h00A1B2C3, 2'd3);
        access(1, 0, 32'h00, 32'h0, 2'd0);
        lit("s3_0x01", bus.data_read_fDM, 32'h55A1B2C3);

        // Out of range: zero data, error pulse, no aliasing onto word 0
        access(1, 0, 32'h00001000, 32'h0, 2'd0);
        lit("lw_oor_data", bus.data_read_fDM, 32'h0);
        access(0, 1, 32'h00001000, 32'hFFFFFFFF, 2'd0);
        access(0, 1, 32'h40000000, 32'hFFFFFFFF, 2'd0);
        access(1, 0, 32'h00, 32'h0, 2'd0);
        lit("no_alias", bus.data_read_fDM, 32'h55A1B2C3);

        // Read and write together: store, old word returned
        access(1, 1, 32'h00, 32'h0BADF00D, 2'd0);
        lit("rw_old", bus.data_read_fDM, 32'h55A1B2C3);
        access(1, 0, 32'h00, 32'h0, 2'd0);
        lit("rw_new", bus.data_read_fDM, 32'h0BADF00D);

        // Last word in range
        access(0, 1, 32'hFFC, 32'h13579BDF, 2'd0);
        access(0, 1, 32'hFFF, 32'h00000077, 2'd1);
        access(1, 0, 32'hFFC, 32'h0, 2'd0);
        lit("top_word", bus.data_read_fDM, 32'h13579B77);

        // Reset in the middle of a store aborts it
        access(0, 1, 32'h20, 32'h01020304, 2'd0);
        @(posedge CLK); #1;
        bus.data_address_2DM    = 32'h20;
        bus.data_write_2DM      = 32'hCAFEF00D;
        bus.data_write_size_2DM = 2'd0;
        bus.MemWrite_2DM        = 1'b1;
        e_stall = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b1;
        e_stall = 1'b0;
        e_err   = 1'b0;
        e_data  = 32'h0;
        e_dk    = 1'b1;
        #1;
        lit("abort_stall", {31'h0, bus.MEM_stall}, 32'h0);
        lit("abort_data",  bus.data_read_fDM, 32'h0);
        bus.MemWrite_2DM = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        access(1, 0, 32'h20, 32'h0, 2'd0);
        lit("abort_no_commit", bus.data_read_fDM, 32'h01020304);

        @(posedge CLK); #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
